audio_sample_player: RTL and testbench

- Downstream consumer of the 44.1 kHz audio clock generator.
- Buffers audio samples from a producer through a valid/ready handshake.
- Pops one sample per rising edge of the audio clock and converts it to a 1-bit first-order delta-sigma stream on a Pmod pin, which an RC filter turns into analog audio.
- Runs entirely in the system clk domain. audio_clk comes from the clock generator, is derived from clk, and is sampled as a level.

---
 rtl/audio_player_pkg.sv | 19 +
 rtl/audio_sample_player_if.sv | 17 +
 rtl/audio_sample_player_sync_fifo.sv | 66 ++++++
 rtl/audio_sample_player.sv | 95 +++++++++
 tb/tb_audio_sample_player.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_player_pkg.sv
// Shared constants and helpers for the audio sample player.
//   SAMPLE_W_DEFAULT   : default sample width in bits
//   FIFO_DEPTH_DEFAULT : default buffer depth (power of two, >= 2)
//   midscale(w)        : offset-binary silence code, 2^(w-1)
//   level_w(depth)     : width of an occupancy count 0..depth
package audio_player_pkg;

  localparam int unsigned SAMPLE_W_DEFAULT   = 8;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/audio_sample_player_if.sv
// Sample stream handshake between a producer and the audio sample player.
//   s_data  : unsigned offset-binary sample
//   s_valid : producer has a sample on s_data
//   s_ready : consumer can accept a sample (push = s_valid && s_ready)
// Modports: master = producer, slave = consumer.
interface audio_sample_player_if #(
  parameter int unsigned SAMPLE_W = 8
) ();

  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/audio_sample_player_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data (ignored while full)
//   i_data    : write data
//   i_pop     : advance the head (ignored while empty)
//   o_head    : head entry, valid while !o_empty
//   o_full    : level == DEPTH
//   o_empty   : level == 0
//   o_level   : current occupancy
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DEPTH   = 16,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_level == LEVEL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_player.sv
// Audio sample player: buffers producer samples and plays one per rising
// edge of audio_clk as a first-order delta-sigma bitstream.
//   clk       : system clock (audio_clk is derived from it, sampled as level)
//   reset     : asynchronous active-high reset
//   audio_clk : 44.1 kHz square wave
//   s         : sample handshake (slave side)
//   mute      : only with AUDIO_PLAYER_MUTE_EN; ticks load silence instead of data
//   dac_out   : delta-sigma bit, density = sample / 2^SAMPLE_W
//   underrun  : sticky, a tick found the buffer empty
//   level     : buffer occupancy
// Optional feature macro: AUDIO_PLAYER_MUTE_EN.
module audio_sample_player
  import audio_player_pkg::*;
#(
  parameter  int unsigned SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned LEVEL_W    = level_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  audio_clk,
  audio_sample_player_if.slave  s,
`ifdef AUDIO_PLAYER_MUTE_EN
  input  logic                  mute,
`endif
  output logic                  dac_out,
  output logic                  underrun,
  output logic [LEVEL_W-1:0]    level
);

  localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(midscale(SAMPLE_W));

  logic                r_prev;
  logic                r_underrun;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W:0]   r_acc;

  logic                w_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [SAMPLE_W-1:0] w_head;
  logic [SAMPLE_W-1:0] w_load;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign s.s_ready = ~w_full;
  assign w_push    = s.s_valid & ~w_full;
  assign w_tick    = audio_clk & ~r_prev;
  assign w_pop     = w_tick & ~w_empty;

`ifdef AUDIO_PLAYER_MUTE_EN
  assign w_load = mute ? MIDSCALE : w_head;
`else
  assign w_load = w_head;
`endif

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (s.s_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev     <= 1'b0;
      r_underrun <= 1'b0;
      r_sample   <= MIDSCALE;
    end else begin
      r_prev <= audio_clk;
      if (w_tick && w_empty) r_underrun <= 1'b1;
      if (w_pop)             r_sample   <= w_load;
    end
  end

  // Carry out of the low SAMPLE_W bits is the output bit; it is dropped
  // before the next add so the residue stays in range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc <= '0;
    else       r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, r_sample};
  end

  assign dac_out  = r_acc[SAMPLE_W];
  assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_sample_player.sv
module tb_audio_sample_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       audio_clk;
  logic       dac_out;
  logic       underrun;
  logic [4:0] level;
`ifdef AUDIO_PLAYER_MUTE_EN
  logic       mute;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  audio_sample_player_if #(.SAMPLE_W(8)) bus ();

  audio_sample_player #(
    .SAMPLE_W   (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .audio_clk (audio_clk),
    .s         (bus.slave),
`ifdef AUDIO_PLAYER_MUTE_EN
    .mute      (mute),
`endif
    .dac_out   (dac_out),
    .underrun  (underrun),
    .level     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    reset       = 1'b1;
    audio_clk   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
`ifdef AUDIO_PLAYER_MUTE_EN
    mute        = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
  endtask

  task do_tick();
    audio_clk = 1'b1;
    step();
    audio_clk = 1'b0;
    step();
  endtask

  task count_ones(input int unsigned n, output int unsigned ones);
    ones = 0;
    for (int unsigned i = 0; i < n; i++) begin
      step();
      if (dac_out === 1'b1) ones++;
    end
  endtask

  task test_reset();
    reset       = 1'b1;
    audio_clk   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
`ifdef AUDIO_PLAYER_MUTE_EN
    mute        = 1'b0;
`endif
    #1;
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    n_tests++;
    if (dac_out !== 1'b0) begin n_fail++; $display("FAIL reset_dac_out: got %b expected 0", dac_out); end
    step();
    step();
    reset = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (dac_out !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL reset_midscale_pattern cycle %0d: got %b expected %b", k, dac_out, ((k % 2) == 0));
      end
    end
    audio_clk = 1'b1;
    step();
    audio_clk = 1'b0;
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL empty_tick_underrun: got %b expected 1", underrun); end
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL empty_tick_level: got %0d expected 0", level); end
  endtask

  task test_density();
    int unsigned ones;
    do_reset();
    bus.s_data  = 8'h40;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    n_tests++;
    if (level !== 5'd1) begin n_fail++; $display("FAIL density_level_push: got %0d expected 1", level); end
    audio_clk = 1'b1;
    step();
    audio_clk = 1'b0;
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL density_level_pop: got %0d expected 0", level); end
    count_ones(256, ones);
    n_tests++;
    if (ones !== 64) begin n_fail++; $display("FAIL density_0x40: got %0d ones expected 64", ones); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL density_underrun: got %b expected 0", underrun); end
  endtask

  task test_full_wrap();
    int unsigned ones;
    do_reset();
    for (int unsigned i = 1; i <= 16; i++) begin
      bus.s_data  = 8'(i);
      bus.s_valid = 1'b1;
      step();
    end
    n_tests++;
    if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d expected 16", level); end
    n_tests++;
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready: got %b expected 0", bus.s_ready); end
    bus.s_data = 8'h11;
    step();
    step();
    step();
    n_tests++;
    if (level !== 5'd16) begin n_fail++; $display("FAIL full_hold_level: got %0d expected 16", level); end
    // Pop while full: the held push is still refused this cycle.
    audio_clk = 1'b1;
    step();
    audio_clk = 1'b0;
    n_tests++;
    if (level !== 5'd15) begin n_fail++; $display("FAIL full_pop_level: got %0d expected 15", level); end
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_s_ready: got %b expected 1", bus.s_ready); end
    step();
    bus.s_valid = 1'b0;
    n_tests++;
    if (level !== 5'd16) begin n_fail++; $display("FAIL held_push_level: got %0d expected 16", level); end
    count_ones(256, ones);
    n_tests++;
    if (ones !== 1) begin n_fail++; $display("FAIL order_sample_1: got %0d ones expected 1", ones); end
    for (int unsigned v = 2; v <= 17; v++) begin
      do_tick();
      count_ones(256, ones);
      n_tests++;
      if (ones !== v) begin n_fail++; $display("FAIL order_sample_%0d: got %0d ones expected %0d", v, ones, v); end
    end
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level: got %0d expected 0", level); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL drain_underrun: got %b expected 0", underrun); end
  endtask

  task test_empty_push_tick();
    int unsigned ones;
    do_reset();
    bus.s_data  = 8'hC0;
    bus.s_valid = 1'b1;
    audio_clk   = 1'b1;
    step();
    bus.s_valid = 1'b0;
    audio_clk   = 1'b0;
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL ept_underrun: got %b expected 1", underrun); end
    n_tests++;
    if (level !== 5'd1) begin n_fail++; $display("FAIL ept_level: got %0d expected 1", level); end
    count_ones(256, ones);
    n_tests++;
    if (ones !== 128) begin n_fail++; $display("FAIL ept_no_bypass: got %0d ones expected 128", ones); end
    do_tick();
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL ept_level_after: got %0d expected 0", level); end
    count_ones(256, ones);
    n_tests++;
    if (ones !== 192) begin n_fail++; $display("FAIL ept_sample_0xC0: got %0d ones expected 192", ones); end
  endtask

  task test_reset_mid();
    do_reset();
    do_tick();
    for (int unsigned i = 0; i < 8; i++) begin
      bus.s_data  = 8'(8'h10 + i);
      bus.s_valid = 1'b1;
      step();
    end
    bus.s_valid = 1'b0;
    do_tick();
    n_tests++;
    if (level !== 5'd7) begin n_fail++; $display("FAIL mid_pre_level: got %0d expected 7", level); end
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL mid_pre_underrun: got %b expected 1", underrun); end
    for (int unsigned i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b expected 1", bus.s_ready); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL mid_underrun: got %b expected 0", underrun); end
    n_tests++;
    if (dac_out !== 1'b0) begin n_fail++; $display("FAIL mid_dac_out: got %b expected 0", dac_out); end
    #1;
    reset = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (dac_out !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL mid_midscale_pattern cycle %0d: got %b expected %b", k, dac_out, ((k % 2) == 0));
      end
    end
  endtask

`ifdef AUDIO_PLAYER_MUTE_EN
  task test_mute();
    int unsigned ones;
    logic        prev;
    do_reset();
    mute        = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    step();
    bus.s_data  = 8'h00;
    step();
    bus.s_valid = 1'b0;
    n_tests++;
    if (level !== 5'd2) begin n_fail++; $display("FAIL mute_level_2: got %0d expected 2", level); end
    do_tick();
    n_tests++;
    if (level !== 5'd1) begin n_fail++; $display("FAIL mute_level_1: got %0d expected 1", level); end
    prev = dac_out;
    for (int unsigned k = 0; k < 8; k++) begin
      step();
      n_tests++;
      if (dac_out !== ~prev) begin n_fail++; $display("FAIL mute_alternate cycle %0d: got %b expected %b", k, dac_out, ~prev); end
      prev = dac_out;
    end
    do_tick();
    n_tests++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL mute_level_0: got %0d expected 0", level); end
    count_ones(256, ones);
    n_tests++;
    if (ones !== 128) begin n_fail++; $display("FAIL mute_density: got %0d ones expected 128", ones); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL mute_underrun: got %b expected 0", underrun); end
    mute = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_density();
    test_full_wrap();
    test_empty_push_tick();
    test_reset_mid();
`ifdef AUDIO_PLAYER_MUTE_EN
    test_mute();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
